// File: rtl/regfile_dumper_pkg.sv
// Shared debug-unit constants and FSM encoding
// for the register file dumper.
package regfile_dumper_pkg;

  localparam int NB_REGS        = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_dumper_word_serializer.sv
// Captures one regfile word and shifts it out
// one byte at a time, least-significant first.
module regfile_dumper_word_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int NB_BYTE    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [NB_BYTE-1:0]    data,
  output logic                  last
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [DATA_WIDTH-1:0] word_reg;
  logic [CW-1:0]         byte_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      word_reg <= word;
      byte_cnt <= '0;
    end else if (shift && !last) begin
      word_reg <= word_reg >> NB_BYTE;
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  assign last = (byte_cnt == CW'(NBYTES - 1));
  assign data = word_reg[NB_BYTE-1:0];

endmodule

// File: rtl/regfile_dumper.sv
// Reads x0..x31 through a spare regfile port and
// streams each word out little-endian as bytes.
module regfile_dumper
  import regfile_dumper_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NB_BYTE    = 8
) (
  input  logic                      clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  output logic [REG_ADDR_WIDTH-1:0] o_addr,
  input  logic [DATA_WIDTH-1:0]     i_rdata,
  output logic [NB_BYTE-1:0]        o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam logic [REG_ADDR_WIDTH-1:0] LAST_REG =
    REG_ADDR_WIDTH'(NB_REGS - 1);

  state_t                    state, state_nxt;
  logic [REG_ADDR_WIDTH-1:0] reg_idx;
  logic                      load, shift, last;
  logic [NB_BYTE-1:0]        ser_data;

  regfile_dumper_word_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .NB_BYTE    (NB_BYTE)
  ) u_ser (
    .clk   (clk),
    .rst   (i_rst),
    .load  (load),
    .shift (shift),
    .word  (i_rdata),
    .data  (ser_data),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    unique case (state)
      IDLE: if (i_start) state_nxt = LOAD;
      LOAD: begin
        load      = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (i_ready) begin
          shift = 1'b1;
          if (last) begin
            state_nxt = (reg_idx == LAST_REG) ? DONE : LOAD;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // reg_idx returns to 0 after DONE so a new dump starts clean
  always_ff @(posedge clk) begin
    if (i_rst) begin
      reg_idx <= '0;
    end else begin
      unique case (state)
        IDLE: if (i_start) reg_idx <= '0;
        SEND: begin
          if (i_ready && last && reg_idx != LAST_REG) begin
            reg_idx <= reg_idx + 1'b1;
          end
        end
        DONE: reg_idx <= '0;
        default: reg_idx <= reg_idx;
      endcase
    end
  end

  assign o_addr  = (state == IDLE) ? '0 : reg_idx;
  assign o_valid = (state == SEND);
  assign o_data  = o_valid ? ser_data : '0;
  assign o_busy  = (state == LOAD) || (state == SEND);
  assign o_done  = (state == DONE);

endmodule

// File: tb/tb_regfile_dumper.sv
// Bench for regfile_dumper: regfile model plus an
// expected byte stream built from register snapshots.
module tb_regfile_dumper;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_ready;
  logic [4:0]  o_addr;
  logic [31:0] i_rdata;
  logic [7:0]  o_data;
  logic        o_valid, o_busy, o_done;

  always #5 clk = ~clk;

  regfile_dumper dut (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .o_addr  (o_addr),
    .i_rdata (i_rdata),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  logic [31:0] rf [32];
  assign i_rdata = (o_addr == 5'd0) ? 32'd0 : rf[o_addr];

  int errors = 0;
  int checks = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] base_q[$];
  int done_cnt, done_cyc, first_valid, ncyc, nbad;
  int abort_at, restart_reg, ready_pct;
  bit write_x2, restarted, wrote;

  function automatic void build_expected();
    logic [31:0] w;
    exp_q.delete();
    for (int r = 0; r < 32; r++) begin
      w = (r == 0) ? 32'd0 : rf[r];
      for (int b = 0; b < 4; b++)
        exp_q.push_back(8'(w >> (8 * b)));
    end
  endfunction

  function automatic void preload();
    for (int r = 0; r < 32; r++) rf[r] = 32'd0;
    rf[1]  = 32'h11223344;
    rf[31] = 32'hDEADBEEF;
  endfunction

  function automatic void randomize_rf();
    for (int r = 0; r < 32; r++) rf[r] = $urandom;
  endfunction

  task automatic cycle();
    logic hs, stall;
    logic [7:0] d;
    hs    = o_valid && i_ready && !i_rst;
    stall = o_valid && !i_ready && !i_rst;
    d     = o_data;
    @(posedge clk);
    #1;
    ncyc++;
    if (hs) got.push_back(d);
    if (stall) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== d) begin
        errors++;
        $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                 o_valid, o_data, d);
      end
    end
    if (o_done) done_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      i_ready = 1'b1;
      cycle();
    end
  endtask

  task automatic run_dump();
    got.delete();
    done_cnt    = 0;
    done_cyc    = 0;
    first_valid = 0;
    restarted   = 0;
    wrote       = 0;
    ncyc        = 0;
    i_start     = 1'b1;
    cycle();
    i_start = 1'b0;
    while (done_cnt == 0 && ncyc < 3000) begin
      if (abort_at >= 0 && got.size() == abort_at && o_valid) return;
      i_ready = ($urandom_range(0, 99) < ready_pct);
      if (restart_reg >= 0 && !restarted && o_valid
          && o_addr == 5'(restart_reg)) begin
        i_start   = 1'b1;
        restarted = 1;
      end
      if (write_x2 && !wrote && o_valid && o_addr == 5'd2) begin
        rf[2] = 32'hCAFEF00D;
        wrote = 1;
      end
      cycle();
      i_start = 1'b0;
      if (first_valid == 0 && o_valid) first_valid = ncyc;
      if (o_done && done_cyc == 0) done_cyc = ncyc;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL dump_timeout: no o_done after %0d cycles, required one",
               ncyc);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b1;
    cycle();
    cycle();
    checks++;
    if (o_addr !== 5'd0) begin
      errors++; $display("FAIL rst_addr: got %h, required 00", o_addr);
    end
    checks++;
    if (o_data !== 8'd0) begin
      errors++; $display("FAIL rst_data: got %h, required 00", o_data);
    end
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid: got %b, required 0", o_valid);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy: got %b, required 0", o_busy);
    end
    checks++;
    if (o_done !== 1'b0) begin
      errors++; $display("FAIL rst_done: got %b, required 0", o_done);
    end
    i_rst = 1'b0;
    cycle();
  endtask

  task automatic test_basic();
    preload();
    build_expected();
    base_q = exp_q;
    ready_pct = 100; abort_at = -1; restart_reg = -1; write_x2 = 0;
    run_dump();
    checks++;
    if (first_valid != 2) begin
      errors++;
      $display("FAIL first_valid: got cycle %0d, required 2", first_valid);
    end
    checks++;
    if (done_cyc != 161) begin
      errors++;
      $display("FAIL done_latency: got %0d, required 161", done_cyc);
    end
    checks++;
    if (got.size() != 128) begin
      errors++;
      $display("FAIL basic_count: got %0d bytes, required 128", got.size());
    end
    checks++;
    if ({got[3], got[2], got[1], got[0]} !== 32'h0) begin
      errors++;
      $display("FAIL basic_x0: got %h, required 00000000",
               {got[3], got[2], got[1], got[0]});
    end
    checks++;
    if ({got[7], got[6], got[5], got[4]} !== 32'h11223344) begin
      errors++;
      $display("FAIL basic_x1: got %h, required 11223344",
               {got[7], got[6], got[5], got[4]});
    end
    checks++;
    if ({got[127], got[126], got[125], got[124]} !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_x31: got %h, required deadbeef",
               {got[127], got[126], got[125], got[124]});
    end
    checks++;
    nbad = 0;
    foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nbad++;
    if (got.size() != exp_q.size() || nbad != 0) begin
      errors++;
      $display("FAIL basic_seq: %0d bad of %0d bytes, required 0 bad of %0d",
               nbad, got.size(), exp_q.size());
    end
    idle(5);
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL basic_done_once: got %0d pulses, required 1", done_cnt);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle_busy: got %b, required 0", o_busy);
    end
  endtask

  task automatic test_backpressure();
    preload();
    ready_pct = 50; abort_at = -1; restart_reg = -1; write_x2 = 0;
    run_dump();
    checks++;
    nbad = 0;
    foreach (base_q[i]) if (i >= got.size() || got[i] !== base_q[i]) nbad++;
    if (got.size() != base_q.size() || nbad != 0) begin
      errors++;
      $display("FAIL bp_seq: %0d bad of %0d bytes, required 0 bad of %0d",
               nbad, got.size(), base_q.size());
    end
    idle(3);
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL bp_done_once: got %0d pulses, required 1", done_cnt);
    end
  endtask

  task automatic test_restart();
    preload();
    ready_pct = 100; abort_at = -1; restart_reg = 5; write_x2 = 0;
    run_dump();
    restart_reg = -1;
    checks++;
    if (restarted != 1) begin
      errors++;
      $display("FAIL restart_pulsed: got %0d, required 1", restarted);
    end
    checks++;
    nbad = 0;
    foreach (base_q[i]) if (i >= got.size() || got[i] !== base_q[i]) nbad++;
    if (got.size() != 128 || nbad != 0) begin
      errors++;
      $display("FAIL restart_seq: %0d bad of %0d bytes, required 0 bad of 128",
               nbad, got.size());
    end
    idle(5);
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL restart_done_once: got %0d, required 1", done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    preload();
    ready_pct = 100; abort_at = 42; restart_reg = -1; write_x2 = 0;
    run_dump();
    abort_at = -1;
    checks++;
    if (o_addr !== 5'd10 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_position: addr=%0d valid=%b, required 10 and 1",
               o_addr, o_valid);
    end
    i_ready = 1'b0;
    i_rst   = 1'b1;
    cycle();
    checks++;
    if ({o_addr, o_data, o_valid, o_busy, o_done} !== 16'd0) begin
      errors++;
      $display("FAIL mid_rst_outputs: addr=%h data=%h v=%b b=%b d=%b, required 0",
               o_addr, o_data, o_valid, o_busy, o_done);
    end
    i_rst = 1'b0;
    cycle();
    build_expected();
    ready_pct = 100;
    run_dump();
    checks++;
    nbad = 0;
    foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nbad++;
    if (got.size() != 128 || nbad != 0) begin
      errors++;
      $display("FAIL mid_restart_seq: %0d bad of %0d bytes, required 0 of 128",
               nbad, got.size());
    end
    idle(2);
  endtask

  task automatic test_snapshot();
    preload();
    build_expected();
    ready_pct = 70; abort_at = -1; restart_reg = -1; write_x2 = 1;
    run_dump();
    write_x2 = 0;
    checks++;
    if (wrote != 1) begin
      errors++; $display("FAIL snap_wrote: got %0d, required 1", wrote);
    end
    checks++;
    nbad = 0;
    foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nbad++;
    if (got.size() != 128 || nbad != 0) begin
      errors++;
      $display("FAIL snap_old_seq: %0d bad of %0d bytes, required 0 of 128",
               nbad, got.size());
    end
    idle(2);
    build_expected();
    ready_pct = 100;
    run_dump();
    checks++;
    if ({got[11], got[10], got[9], got[8]} !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL snap_new_x2: got %h, required cafef00d",
               {got[11], got[10], got[9], got[8]});
    end
    checks++;
    nbad = 0;
    foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nbad++;
    if (got.size() != 128 || nbad != 0) begin
      errors++;
      $display("FAIL snap_new_seq: %0d bad of %0d bytes, required 0 of 128",
               nbad, got.size());
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    randomize_rf();
    build_expected();
    ready_pct = 100; abort_at = -1; restart_reg = -1; write_x2 = 0;
    run_dump();
    idle(1);
    run_dump();
    checks++;
    if (done_cyc != 161) begin
      errors++;
      $display("FAIL b2b_latency: got %0d, required 161", done_cyc);
    end
    checks++;
    nbad = 0;
    foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nbad++;
    if (got.size() != 128 || nbad != 0) begin
      errors++;
      $display("FAIL b2b_seq: %0d bad of %0d bytes, required 0 of 128",
               nbad, got.size());
    end
    idle(2);
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      randomize_rf();
      build_expected();
      ready_pct = $urandom_range(30, 90);
      abort_at = -1; restart_reg = -1; write_x2 = 0;
      run_dump();
      checks++;
      nbad = 0;
      foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nbad++;
      if (got.size() != 128 || nbad != 0) begin
        errors++;
        $display("FAIL rand_seq[%0d]: %0d bad of %0d bytes, required 0 of 128",
                 k, nbad, got.size());
      end
      idle(2);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b0;
    abort_at = -1; restart_reg = -1; write_x2 = 0; ready_pct = 100;
    for (int r = 0; r < 32; r++) rf[r] = 32'd0;
    test_reset();
    test_basic();
    test_backpressure();
    test_restart();
    test_reset_mid();
    test_snapshot();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
